// File: rtl/dl_pipe_reg_rst.sv
// Elastic pipeline register: NUM_STAGES valid/ready stages with bubble collapse,
// synchronous flush and a registered occupancy count.

module dl_pipe_stage #(
  parameter int                  NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0] RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                adv,
  input  logic                src_valid,
  input  logic [NUM_BITS-1:0] src_data,
  output logic                valid,
  output logic [NUM_BITS-1:0] data
);

  // Data only loads from a valid source so an empty stage keeps its last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= RST_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= src_valid;
      if (src_valid) data <= src_data;
    end
  end

endmodule

module dl_pipe_reg_rst #(
  parameter int                  NUM_BITS   = 32,
  parameter int                  NUM_STAGES = 2,
  parameter logic [NUM_BITS-1:0] RST_VAL    = '0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_BITS-1:0]               in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_BITS-1:0]               out_data,
  output logic [$clog2(NUM_STAGES+1)-1:0]   count
);

  localparam int CW = $clog2(NUM_STAGES+1);

  logic [NUM_STAGES-1:0]               vld;
  logic [NUM_STAGES-1:0]               adv;
  logic [NUM_STAGES-1:0]               src_vld;
  logic [NUM_STAGES-1:0]               vld_nxt;
  logic [NUM_STAGES-1:0][NUM_BITS-1:0] dat;
  logic [NUM_STAGES-1:0][NUM_BITS-1:0] src_dat;
  logic [CW-1:0]                       cnt_nxt;

  // Ready ripples from the output back to the input; any bubble ahead lets a stage move.
  always_comb begin
    adv = '0;
    adv[NUM_STAGES-1] = out_ready | ~vld[NUM_STAGES-1];
    for (int i = NUM_STAGES-2; i >= 0; i--)
      adv[i] = ~vld[i] | adv[i+1];
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign src_vld[g] = in_valid;
      assign src_dat[g] = in_data;
    end else begin : g_body
      assign src_vld[g] = vld[g-1];
      assign src_dat[g] = dat[g-1];
    end

    dl_pipe_stage #(
      .NUM_BITS (NUM_BITS),
      .RST_VAL  (RST_VAL)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .adv       (adv[g]),
      .src_valid (src_vld[g]),
      .src_data  (src_dat[g]),
      .valid     (vld[g]),
      .data      (dat[g])
    );
  end

  // Count tracks the valid bits the stages will hold after this edge.
  always_comb begin
    vld_nxt = flush ? '0 : ((adv & src_vld) | (~adv & vld));
    cnt_nxt = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      cnt_nxt = cnt_nxt + CW'(vld_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= cnt_nxt;
  end

  assign in_ready  = adv[0];
  assign out_valid = vld[NUM_STAGES-1];
  assign out_data  = dat[NUM_STAGES-1];

endmodule
